// File: rtl/prime_fifo_writer.sv
// ---------------------------------------------------------------------------
// prime_fifo_writer
//
// Write side of the prime FIFO that feeds the p/q/r/s supply block. Starting
// from a loaded seed, it walks odd full-width candidates and offers each one
// to an external primality tester. Every candidate reported prime is pushed
// into the FIFO. When the FIFO is full, the writer waits and does not drop
// the candidate. If too many composites arrive in a row, it raises a sticky
// fail flag and parks in IDLE until a new seed is loaded.
//
// Ports:
//   aclk          clock
//   aresetn       asynchronous active-low reset
//   enable        level; search runs while high (sampled in IDLE and STEP)
//   seed_load     one-cycle pulse, honoured only in IDLE
//   seed          starting point; MSB and LSB are forced to 1 on load
//   test_start    one-cycle pulse, test_cand valid
//   test_cand     candidate under test, stable from test_start to test_done
//   test_done     one-cycle pulse from the tester
//   test_is_prime tester verdict, valid with test_done
//   fifo_full     FIFO cannot accept a write this cycle
//   fifo_wr_en    FIFO write strobe
//   fifo_din      FIFO write data (same register as test_cand)
//   prime_count   primes written since reset/seed_load, wraps
//   search_fail   sticky; MAX_TRIES consecutive composites seen
//   busy          high in every state except IDLE
// ---------------------------------------------------------------------------
module prime_fifo_writer #(
    parameter int WIDTH     = 512,
    parameter int MAX_TRIES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic             test_start,
    output logic [WIDTH-1:0] test_cand,
    input  logic             test_done,
    input  logic             test_is_prime,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_din,
    output logic [CNT_W-1:0] prime_count,
    output logic             search_fail,
    output logic             busy
);

    // Smallest odd value with the top bit set: used both as the mask forced
    // onto a loaded seed and as the restart point after the search wraps.
    localparam logic [WIDTH-1:0] FULL_ODD    = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIES_LIMIT = CNT_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        STEP  = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cand;
    logic             seeded;
    logic [CNT_W-1:0] tries;

    // Next odd candidate. Running past the top of the word restarts the
    // search at the smallest full-width odd value, not at a tiny number.
    function automatic logic [WIDTH-1:0] next_cand(input logic [WIDTH-1:0] c);
        logic [WIDTH:0] sum;
        sum = {1'b0, c} + (WIDTH+1)'(2);
        if (sum[WIDTH])
            next_cand = FULL_ODD;
        else
            next_cand = sum[WIDTH-1:0];
    endfunction

    // A seed is made odd and full-width before it is tested.
    function automatic logic [WIDTH-1:0] shape_seed(input logic [WIDTH-1:0] s);
        shape_seed = s | FULL_ODD;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            cand        <= '0;
            seeded      <= 1'b0;
            tries       <= '0;
            prime_count <= '0;
            test_start  <= 1'b0;
            search_fail <= 1'b0;
        end else begin
            test_start <= 1'b0;
            case (state)
                IDLE: begin
                    // A load takes priority over starting. ISSUE then follows
                    // on the next cycle, once the new candidate is in place.
                    if (seed_load) begin
                        cand        <= shape_seed(seed);
                        seeded      <= 1'b1;
                        tries       <= '0;
                        prime_count <= '0;
                        search_fail <= 1'b0;
                    end else if (enable && seeded && !search_fail) begin
                        state      <= ISSUE;
                        test_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    // A test_done in this cycle belongs to no request and is
                    // not looked at.
                    state <= WAIT;
                end
                WAIT: begin
                    if (test_done) begin
                        if (test_is_prime) begin
                            state <= WRITE;
                        end else begin
                            tries <= tries + CNT_ONE;
                            if (tries + CNT_ONE == TRIES_LIMIT) begin
                                search_fail <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                state <= STEP;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!fifo_full) begin
                        prime_count <= prime_count + CNT_ONE;
                        tries       <= '0;
                        state       <= STEP;
                    end
                end
                STEP: begin
                    cand <= next_cand(cand);
                    if (enable) begin
                        state      <= ISSUE;
                        test_start <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe must drop in the same cycle fifo_full rises, so it is
    // decoded directly from the state rather than registered.
    assign fifo_wr_en = (state == WRITE) && !fifo_full;
    assign fifo_din   = cand;
    assign test_cand  = cand;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_prime_fifo_writer.sv
module tb_prime_fifo_writer;

    localparam int WIDTH     = 16;
    localparam int MAX_TRIES = 4;
    localparam int CNT_W     = 16;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             enable = 1'b0;
    logic             seed_load = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic             test_start;
    logic [WIDTH-1:0] test_cand;
    logic             test_done = 1'b0;
    logic             test_is_prime = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_din;
    logic [CNT_W-1:0] prime_count;
    logic             search_fail;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int start_cnt = 0;

    prime_fifo_writer #(
        .WIDTH(WIDTH), .MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .seed_load(seed_load), .seed(seed),
        .test_start(test_start), .test_cand(test_cand),
        .test_done(test_done), .test_is_prime(test_is_prime),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .prime_count(prime_count), .search_fail(search_fail), .busy(busy)
    );

    always #5 aclk = ~aclk;

    // Count the strobes the DUT actually acts on at each rising edge.
    always @(posedge aclk) begin
        if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
        if (test_start) start_cnt <= start_cnt + 1;
    end

    typedef struct {
        logic [WIDTH-1:0] seed;
        logic [WIDTH-1:0] c0;   // first candidate tested
        logic [WIDTH-1:0] c1;   // candidate after one composite
    } vec_t;

    vec_t vecs[5];

    function automatic bit is_prime16(input logic [WIDTH-1:0] n);
        int v;
        v = int'(n);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        test_done = 1'b0;
        test_is_prime = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic load_seed(input logic [WIDTH-1:0] s);
        seed      = s;
        seed_load = 1'b1;
        enable    = 1'b1;
        @(negedge aclk);
        seed_load = 1'b0;
    endtask

    // Bounded wait for test_start, sampled on falling edges.
    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (test_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Called in the ISSUE cycle; answers in the first WAIT cycle. Returns on
    // the falling edge after the verdict has been taken.
    task automatic respond(input bit prime);
        @(negedge aclk);
        test_done     = 1'b1;
        test_is_prime = prime;
        @(negedge aclk);
        test_done     = 1'b0;
        test_is_prime = 1'b0;
    endtask

    initial begin
        int w0, s0;
        vecs[0] = '{16'h0000, 16'h8001, 16'h8003};
        vecs[1] = '{16'h1234, 16'h9235, 16'h9237};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h8001};
        vecs[3] = '{16'h8002, 16'h8003, 16'h8005};
        vecs[4] = '{16'h7FFE, 16'hFFFF, 16'h8001};

        // Reset state
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_test_start", 32'(test_start), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fail", 32'(search_fail), 0);
        chk("rst_count", 32'(prime_count), 0);
        chk("rst_cand", 32'(test_cand), 0);

        // Unseeded enable must not start a search
        aresetn = 1'b1;
        enable  = 1'b1;
        repeat (3) @(negedge aclk);
        chk("unseeded_busy", 32'(busy), 0);

        // Basic search with true primality and exact latencies
        do_reset();
        w0 = wr_cnt;
        load_seed(16'h8000);
        chk("lat_not_yet", 32'(test_start), 0);
        @(negedge aclk);
        chk("lat_start", 32'(test_start), 1);
        chk("cand0", 32'(test_cand), 32'h8001);
        respond(is_prime16(test_cand));
        chk("after_comp_no_start", 32'(test_start), 0);
        @(negedge aclk);
        chk("comp_to_start", 32'(test_start), 1);
        chk("cand1", 32'(test_cand), 32'h8003);
        respond(is_prime16(test_cand));
        chk("wr_en", 32'(fifo_wr_en), 1);
        chk("din", 32'(fifo_din), 32'h8003);
        enable = 1'b0;
        @(negedge aclk);
        chk("count1", 32'(prime_count), 1);
        @(negedge aclk);
        chk("idle_after", 32'(busy), 0);
        chk("one_write", 32'(wr_cnt - w0), 1);

        // Full stall for 5 cycles
        do_reset();
        w0 = wr_cnt;
        s0 = start_cnt;
        load_seed(16'h8000);
        wait_start("st_start0");
        respond(is_prime16(test_cand));
        wait_start("st_start1");
        fifo_full = 1'b1;
        respond(is_prime16(test_cand));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_%0d", k), 32'(fifo_wr_en), 0);
            chk($sformatf("stall_busy_%0d", k), 32'(busy), 1);
            if (k < 4) @(negedge aclk);
        end
        fifo_full = 1'b0;
        enable    = 1'b0;
        #1;
        chk("stall_wr", 32'(fifo_wr_en), 1);
        chk("stall_din", 32'(fifo_din), 32'h8003);
        repeat (3) @(negedge aclk);
        chk("stall_no_dup", 32'(wr_cnt - w0), 1);
        chk("stall_starts", 32'(start_cnt - s0), 2);
        chk("stall_count", 32'(prime_count), 1);

        // Table: seed shaping, stepping, wrap-around
        foreach (vecs[i]) begin
            do_reset();
            load_seed(vecs[i].seed);
            wait_start($sformatf("v%0d_start0", i));
            chk($sformatf("v%0d_c0", i), 32'(test_cand), 32'(vecs[i].c0));
            respond(1'b0);
            wait_start($sformatf("v%0d_start1", i));
            chk($sformatf("v%0d_c1", i), 32'(test_cand), 32'(vecs[i].c1));
            enable = 1'b0;
            respond(1'b1);
            chk($sformatf("v%0d_wr", i), 32'(fifo_wr_en), 1);
            chk($sformatf("v%0d_din", i), 32'(fifo_din), 32'(vecs[i].c1));
            repeat (2) @(negedge aclk);
            chk($sformatf("v%0d_count", i), 32'(prime_count), 1);
            chk($sformatf("v%0d_idle", i), 32'(busy), 0);
        end

        // MAX_TRIES consecutive composites
        do_reset();
        s0 = start_cnt;
        load_seed(16'h8000);
        for (int t = 0; t < MAX_TRIES; t++) begin
            wait_start($sformatf("mt_start%0d", t));
            respond(1'b0);
        end
        chk("mt_fail", 32'(search_fail), 1);
        chk("mt_idle", 32'(busy), 0);
        repeat (5) @(negedge aclk);
        chk("mt_starts", 32'(start_cnt - s0), MAX_TRIES);
        chk("mt_still_idle", 32'(busy), 0);
        load_seed(16'h8000);
        chk("mt_cleared", 32'(search_fail), 0);
        wait_start("mt_restart");
        enable = 1'b0;
        respond(1'b1);
        repeat (3) @(negedge aclk);

        // enable dropped during WAIT
        do_reset();
        w0 = wr_cnt;
        s0 = start_cnt;
        load_seed(16'h8002);
        wait_start("en_start");
        enable = 1'b0;
        respond(1'b1);
        chk("en_wr", 32'(fifo_wr_en), 1);
        chk("en_din", 32'(fifo_din), 32'h8003);
        repeat (4) @(negedge aclk);
        chk("en_idle", 32'(busy), 0);
        chk("en_starts", 32'(start_cnt - s0), 1);
        chk("en_writes", 32'(wr_cnt - w0), 1);

        // Reset during WAIT, then a late test_done
        do_reset();
        w0 = wr_cnt;
        load_seed(16'h8002);
        wait_start("ar_start");
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_start0", 32'(test_start), 0);
        chk("ar_cand", 32'(test_cand), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        test_done = 1'b1;
        test_is_prime = 1'b1;
        @(negedge aclk);
        test_done = 1'b0;
        test_is_prime = 1'b0;
        chk("ar_no_wr", 32'(fifo_wr_en), 0);
        @(negedge aclk);
        chk("ar_count", 32'(prime_count), 0);
        chk("ar_writes", 32'(wr_cnt - w0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/prime_fifo_writer.md
Name: prime_fifo_writer

Overview:
- Write side of the prime FIFO that feeds the p/q/r/s supply block.
- Runs an incremental odd-candidate search from a loaded seed.
- Hands each candidate to an external primality tester over a start/done handshake.
- Pushes every candidate reported prime into the FIFO, stalling on full without dropping.
- Raises a sticky fail flag if too many consecutive composites are seen.

Parameters:
- WIDTH, 512, candidate/prime word width in bits (≥4).
- MAX_TRIES, 1024, consecutive composites allowed before search_fail.
- CNT_W, 16, width of prime_count and of the tries counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- enable  in  1  level; search runs while high.
- seed_load  in  1  one-cycle pulse, sampled only in IDLE.
- seed  in  WIDTH  starting point for the search.
- test_start  out  1  one-cycle pulse; test_cand is valid.
- test_cand  out  WIDTH  candidate under test; held stable from test_start until test_done.
- test_done  in  1  one-cycle pulse from tester; test_is_prime is valid.
- test_is_prime  in  1  tester verdict, sampled only with test_done.
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  WIDTH  FIFO write data (equal to test_cand).
- prime_count  out  CNT_W  number of primes written since reset/seed_load; wraps modulo 2^CNT_W.
- search_fail  out  1  sticky; MAX_TRIES consecutive composites seen.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release) clears everything:
  - state=IDLE, cand=0, seeded=0, tries=0, prime_count=0.
  - test_start=0, fifo_wr_en=0, search_fail=0.
- Candidate forming:
  - seed_load in IDLE: cand <= seed with bit WIDTH-1 and bit 0 forced to 1; seeded<=1; tries<=0; prime_count<=0; search_fail<=0.
  - seed_load outside IDLE is ignored.
- State IDLE:
  - Moves to ISSUE when enable=1, seeded=1 and search_fail=0.
  - A seed_load and enable in the same cycle: the load wins and ISSUE is entered the next cycle.
- State ISSUE:
  - test_start=1 for exactly this cycle.
  - Next state is WAIT.
- State WAIT:
  - Holds until test_done=1.
  - test_is_prime=1 -> WRITE.
  - test_is_prime=0 -> tries++. If tries reaches MAX_TRIES: search_fail<=1 and go to IDLE. Otherwise go to STEP.
  - A test_done in the same cycle as ISSUE is ignored.
- State WRITE:
  - fifo_wr_en is combinational: (state==WRITE) && !fifo_full. fifo_din = cand.
  - Stays in WRITE while fifo_full=1; no data is lost.
  - In the cycle the write occurs: prime_count++, tries<=0, then go to STEP.
- State STEP:
  - cand <= cand+2.
  - If the sum overflows WIDTH bits, cand <= 2^(WIDTH-1)+1 (wrap to the smallest full-width odd value).
  - Next state is ISSUE if enable=1, otherwise IDLE.
- Deassertion of enable:
  - Only sampled in IDLE and STEP.
  - An in-flight test and its pending write always complete first.
- Latency:
  - seed_load to first test_start: 2 cycles when enable is already high.
  - test_done(prime) to fifo_wr_en: 1 cycle, plus any full stall.
  - Composite to next test_start: 2 cycles.
- test_cand and fifo_din are driven from the same cand register. They change only in STEP or on seed_load.
- Reset mid-operation aborts immediately. A test_done arriving after reset is ignored (state is IDLE).

Test Plan:
- WIDTH=16, seed_load seed=0x8000, enable=1, tester model computes true primality.
  -> test_cand 0x8001 (composite) then 0x8003 (prime).
  -> fifo_wr_en one cycle with fifo_din=0x8003; prime_count=1.
- Same setup, fifo_full held high 5 cycles when WRITE is entered.
  -> fifo_wr_en low for those 5 cycles, then one pulse with 0x8003.
  -> No duplicate write and no skipped candidate.
- WIDTH=16, seed=0xFFFF, tester returns composite.
  -> next test_cand=0x8001 (wrap-around).
- MAX_TRIES=4, tester always returns composite.
  -> exactly 4 test_start pulses, then search_fail=1, busy=0, state IDLE.
  -> A further enable does nothing until seed_load clears the flag.
- enable dropped while in WAIT, tester then reports prime.
  -> the write completes, then IDLE; no new test_start.
- aresetn asserted during WAIT, then released.
  -> all outputs 0 immediately; a late test_done causes no write; prime_count=0.
